// File: rtl/usrt_pkg.sv
// usrt_pkg: shared USRT types, sizes and parity encoding for the receiver and transmitter.
package usrt_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;
   localparam int DATA_BITS = 8;
   localparam int BAUD_W = 14;
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD = 1'b1;
   function automatic logic parity_err(input logic [DATA_BITS-1:0] data, input logic pbit, input logic mode);
      return (^data ^ pbit) != mode;
   endfunction
endpackage

// File: rtl/usrt_sync.sv
// usrt_sync: two-flop synchroniser for an asynchronous input with a selectable reset value.
module usrt_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RST_VAL;
         q_o <= RST_VAL;
      end else begin
         meta_q <= d_i;
         q_o <= meta_q;
      end
   end
endmodule

// File: rtl/usrt_rx.sv
// usrt_rx: USRT serial receiver, 1 start / 8 data LSB first / parity / 1 stop,
// mid-bit sampling from a clocks-per-bit divisor latched at frame start.
module usrt_rx #(
   parameter int DATA_BITS = usrt_pkg::DATA_BITS,
   parameter int BAUD_W = usrt_pkg::BAUD_W
) (
   input  logic                 i_Pclk,
   input  logic                 i_Reset_n,
   input  logic [BAUD_W-1:0]    i_Baud,
   input  logic                 i_Parity,
   input  logic                 i_Rx,
   output logic [DATA_BITS-1:0] o_Data,
   output logic                 o_Valid,
   output logic                 o_ParityErr,
   output logic                 o_FrameErr,
   output logic                 o_Busy
);
   import usrt_pkg::*;
   localparam int IDX_W = $clog2(DATA_BITS);
   logic rx_s;
   state_e state_q;
   logic [BAUD_W-1:0] cnt_q, baud_q;
   logic [IDX_W-1:0] idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic par_q, pbit_q, expire;
   usrt_sync #(.RST_VAL(1'b1)) u_sync (
      .clk_i (i_Pclk),
      .rst_ni(i_Reset_n),
      .d_i   (i_Rx),
      .q_o   (rx_s)
   );
   assign expire = cnt_q == '0;
   always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         baud_q <= '0;
         idx_q <= '0;
         shift_q <= '0;
         par_q <= 1'b0;
         pbit_q <= 1'b0;
         o_Data <= '0;
         o_Valid <= 1'b0;
         o_ParityErr <= 1'b0;
         o_FrameErr <= 1'b0;
         o_Busy <= 1'b0;
      end else begin
         o_Valid <= 1'b0;
         // every bit-timing state counts down and reloads a full bit period on expiry
         if (state_q != IDLE && state_q != WAIT_HIGH)
            cnt_q <= expire ? baud_q - 1'b1 : cnt_q - 1'b1;
         case (state_q)
            IDLE: if (!rx_s) begin
               cnt_q <= (i_Baud >> 1) - 1'b1;
               baud_q <= i_Baud;
               par_q <= i_Parity;
               o_Busy <= 1'b1;
               state_q <= START;
            end
            START: if (expire) begin
               if (rx_s) begin
                  o_Busy <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  idx_q <= '0;
                  state_q <= DATA;
               end
            end
            DATA: if (expire) begin
               shift_q[idx_q] <= rx_s;
               idx_q <= idx_q + 1'b1;
               if (idx_q == IDX_W'(DATA_BITS - 1)) state_q <= PARITY;
            end
            PARITY: if (expire) begin
               pbit_q <= rx_s;
               state_q <= STOP;
            end
            STOP: if (expire) begin
               o_Data <= shift_q;
               o_Valid <= 1'b1;
               o_ParityErr <= parity_err(shift_q, pbit_q, par_q);
               o_FrameErr <= !rx_s;
               o_Busy <= !rx_s;
               state_q <= rx_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: if (rx_s) begin
               o_Busy <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               o_Busy <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule
